// File: rtl/tweak_enc_pkg.sv
// Shared encoding constants, field widths and loader FSM state codes for the
// instruction encoder/loader.
package tweak_enc_pkg;

  localparam int EW = 2;
  localparam int IW = 6;
  localparam int RW = 12;
  localparam int DW = 24;

  localparam logic [EW-1:0] ENC_0OP = 2'd0;
  localparam logic [EW-1:0] ENC_1OP = 2'd1;
  localparam logic [EW-1:0] ENC_2OP = 2'd2;
  localparam logic [EW-1:0] ENC_3OP = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [EW-1:0] ecode;
    logic [IW-1:0] icode;
    logic [RW-1:0] rcode;
    logic [DW-1:0] dcode;
  } fields_t;

endpackage

// File: rtl/tweak_enc_pack.sv
// Combinational field packer: the exact inverse of the decoder's per-encoding
// split, plus a flag saying whether the fields survived packing intact.
module tweak_enc_pack
  import tweak_enc_pkg::*;
(
  input  logic [EW-1:0] ecode,
  input  logic [IW-1:0] icode,
  input  logic [RW-1:0] rcode,
  input  logic [DW-1:0] dcode,
  output logic [31:0]   word,
  output logic          fit
);

  logic [23:0] lo;

  // Each encoding trades rcode bits for dcode bits; anything outside the kept
  // window is dropped and flagged.
  always_comb begin
    lo  = dcode;
    fit = 1'b0;
    case (ecode)
      ENC_0OP: begin
        lo  = dcode;
        fit = (rcode == '0);
      end
      ENC_1OP: begin
        lo  = {rcode[11:8], dcode[23:4]};
        fit = (rcode[7:0] == 8'h0) && (dcode[3:0] == 4'h0);
      end
      ENC_2OP: begin
        lo  = {dcode[23:8], rcode[11:4]};
        fit = (rcode[3:0] == 4'h0) && (dcode[7:0] == 8'h0);
      end
      ENC_3OP: begin
        lo  = {dcode[23:12], rcode[11:0]};
        fit = (dcode[11:0] == 12'h0);
      end
      default: ;
    endcase
  end

  assign word = {ecode, icode, lo};

endmodule

// File: rtl/tweak_enc_loader.sv
// Instruction encoder/loader: packs field sets into words, buffers them in a
// small FIFO and streams them into imem at wrapping addresses when granted.
module tweak_enc_loader
  import tweak_enc_pkg::*;
#(
  parameter int NUMWORDS   = 8,
  parameter int AW         = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          CLK,
  input  logic          NRES,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_ecode,
  input  logic [5:0]    in_icode,
  input  logic [11:0]   in_rcode,
  input  logic [23:0]   in_dcode,
  input  logic          mem_gnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          fit_err,
  output logic [7:0]    err_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] AMASK = AW'(NUMWORDS - 1);
  localparam logic [AW:0]   NW    = (AW+1)'(NUMWORDS);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   total_q, total_d;
  logic [AW:0]   acc_q, acc_d;
  logic [AW:0]   wr_q, wr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [31:0]   fifo_d [FIFO_DEPTH];
  logic          fit_err_q, fit_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  fields_t     in_f;
  logic [31:0] pk_word;
  logic        pk_fit;
  logic [AW:0] clamp;
  logic        full, empty, push, pop;

  assign in_f = '{ecode: in_ecode, icode: in_icode, rcode: in_rcode, dcode: in_dcode};

  tweak_enc_pack u_pack (
    .ecode (in_f.ecode),
    .icode (in_f.icode),
    .rcode (in_f.rcode),
    .dcode (in_f.dcode),
    .word  (pk_word),
    .fit   (pk_fit)
  );

  assign clamp = (count > NW) ? NW : count;
  assign full  = (occ_q == OW'(FIFO_DEPTH));
  assign empty = (occ_q == '0);

  // Ready looks only at registered occupancy, so a full FIFO never accepts
  // even when a pop happens in the same cycle.
  assign in_ready  = (state_q == ST_LOAD) && !full && (acc_q < total_q);
  assign push      = in_valid && in_ready;
  assign mem_we    = (state_q == ST_LOAD) && !empty && mem_gnt;
  assign pop       = mem_we;
  assign mem_addr  = addr_q;
  assign mem_wdata = fifo_q[rd_ptr_q];
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
  assign fit_err   = fit_err_q;
  assign err_count = err_cnt_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    total_d   = total_q;
    acc_d     = acc_q;
    wr_d      = wr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    occ_d     = occ_q;
    fifo_d    = fifo_q;
    fit_err_d = push && !pk_fit;
    err_cnt_d = err_cnt_q;

    if (push) begin
      fifo_d[wr_ptr_q] = pk_word;
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      acc_d    = acc_q + (AW+1)'(1);
      if (!pk_fit && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      addr_d   = (addr_q + AW'(1)) & AMASK;
      wr_d     = wr_q + (AW+1)'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: ;
    endcase

    case (state_q)
      ST_IDLE: if (start) begin
        addr_d  = base_addr & AMASK;
        total_d = clamp;
        acc_d   = '0;
        wr_d    = '0;
        state_d = (clamp == '0) ? ST_DONE : ST_LOAD;
      end
      // Every accepted word has been written once wr reaches total.
      ST_LOAD: if (wr_d == total_q && occ_d == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      total_q   <= '0;
      acc_q     <= '0;
      wr_q      <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      occ_q     <= '0;
      fifo_q    <= '{default: '0};
      fit_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      total_q   <= total_d;
      acc_q     <= acc_d;
      wr_q      <= wr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      occ_q     <= occ_d;
      fifo_q    <= fifo_d;
      fit_err_q <= fit_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_tweak_enc_loader.sv
// Bench for tweak_enc_loader: hand-computed encoding table, randomized loads
// against an arithmetic model, plus wrap, clamp, backpressure, saturation and reset cases.
module tb_tweak_enc_loader;

  localparam int NW = 8;
  localparam int AW = 4;

  typedef struct packed {
    bit [1:0]  e;
    bit [5:0]  i;
    bit [11:0] r;
    bit [23:0] d;
  } fld_t;

  typedef struct {
    fld_t      f;
    bit [31:0] w;
    bit        fit;
  } vec_t;

  logic          CLK, NRES, start, busy, done, in_valid, in_ready, mem_gnt, mem_we, fit_err;
  logic [AW-1:0] base_addr, mem_addr;
  logic [AW:0]   count;
  logic [1:0]    in_ecode;
  logic [5:0]    in_icode;
  logic [11:0]   in_rcode;
  logic [23:0]   in_dcode;
  logic [31:0]   mem_wdata;
  logic [7:0]    err_count;

  tweak_enc_loader #(.NUMWORDS(NW), .AW(AW), .FIFO_DEPTH(2)) dut (
    .CLK(CLK), .NRES(NRES), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_ecode(in_ecode), .in_icode(in_icode), .in_rcode(in_rcode), .in_dcode(in_dcode),
    .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fit_err(fit_err), .err_count(err_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass = 0, n_tot = 0, cyc = 0, err_model = 0;
  int fe_cnt, done_cnt, done_cyc;
  bit [35:0] wq[$];
  int        wcq[$];
  fld_t      stim_q[$];
  vec_t      tbl[8];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (NRES) begin
      if (mem_we) begin
        wq.push_back({mem_addr, mem_wdata});
        wcq.push_back(cyc);
      end
      if (fit_err) fe_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  // Reference packing straight from the encoding rules, in plain arithmetic.
  function automatic void model(input fld_t f, output bit [31:0] w, output bit fit);
    bit [31:0] lo, r, d;
    r = 32'(f.r);
    d = 32'(f.d);
    case (f.e)
      2'd0: begin lo = d; fit = (r == 0); end
      2'd1: begin lo = (r / 256) * 32'h100000 + d / 16; fit = (r % 256 == 0) && (d % 16 == 0); end
      2'd2: begin lo = (d / 256) * 256 + r / 16; fit = (r % 16 == 0) && (d % 256 == 0); end
      default: begin lo = (d / 4096) * 4096 + r; fit = (d % 4096 == 0); end
    endcase
    w = 32'(f.e) * 32'h40000000 + 32'(f.i) * 32'h1000000 + lo;
  endfunction

  // Decoder side of the round trip.
  function automatic fld_t decode(input bit [31:0] w);
    fld_t f;
    bit [31:0] lo;
    lo = w % 32'h1000000;
    f.e = 2'(w / 32'h40000000);
    f.i = 6'((w / 32'h1000000) % 64);
    case (f.e)
      2'd0: begin f.r = 0; f.d = 24'(lo); end
      2'd1: begin f.r = 12'((lo / 32'h100000) * 256); f.d = 24'((lo % 32'h100000) * 16); end
      2'd2: begin f.d = 24'((lo / 256) * 256); f.r = 12'((lo % 256) * 16); end
      default: begin f.d = 24'((lo / 4096) * 4096); f.r = 12'(lo % 4096); end
    endcase
    return f;
  endfunction

  function automatic fld_t rand_fld(input bit force_err);
    fld_t f;
    f.e = 2'($urandom_range(0, 3));
    f.i = 6'($urandom);
    f.r = 12'($urandom);
    f.d = 24'($urandom);
    if (force_err) begin
      if (f.e == 2'd0) f.r[0] = 1'b1;
      else f.d[0] = 1'b1;
    end else if ($urandom_range(0, 3) != 0) begin
      case (f.e)
        2'd0: f.r = 0;
        2'd1: begin f.r[7:0] = 0; f.d[3:0] = 0; end
        2'd2: begin f.r[3:0] = 0; f.d[7:0] = 0; end
        default: f.d[11:0] = 0;
      endcase
    end
    return f;
  endfunction

  // gmode: 0 = grant and valid always, 1 = random, 2 = grant held off 6 cycles.
  task automatic do_load(input int base, input int cnt, input int gmode);
    int k, guard, ncl, nerr, first_acc;
    bit seen, fit;
    bit [31:0] w;
    ncl = (cnt > NW) ? NW : cnt;
    wq.delete(); wcq.delete();
    fe_cnt = 0; done_cnt = 0; done_cyc = -1;
    start = 1'b1; base_addr = AW'(base); count = (AW+1)'(cnt);
    @(posedge CLK); #1;
    start = 1'b0;
    k = 0; guard = 0; seen = 0; first_acc = -1;
    while (!seen && guard < 300) begin
      case (gmode)
        0: mem_gnt = 1'b1;
        1: mem_gnt = 1'($urandom_range(0, 1));
        default: mem_gnt = (guard >= 6);
      endcase
      in_valid = (k < stim_q.size()) && (gmode != 1 || $urandom_range(0, 3) != 0);
      if (k < stim_q.size()) {in_ecode, in_icode, in_rcode, in_dcode} = stim_q[k];
      @(negedge CLK);
      if (guard == 0) chk("busy_after_start", busy, ncl > 0);
      if (gmode == 2 && guard == 5) begin
        chk("bp_ready_low", in_ready, 0);
        chk("bp_accepts", k, 2);
        chk("bp_no_write", wq.size(), 0);
      end
      if (in_valid && in_ready) begin
        if (k == 0) first_acc = cyc;
        k++;
      end
      if (done) begin
        seen = 1;
        chk("busy_in_done", busy, 0);
        chk("ready_in_done", in_ready, 0);
      end
      guard++;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0; mem_gnt = 1'b0;
    chk("done_seen", seen, 1);
    chk("done_once", done_cnt, 1);
    chk("n_writes", wq.size(), ncl);
    nerr = 0;
    for (int j = 0; j < ncl && j < wq.size(); j++) begin
      model(stim_q[j], w, fit);
      if (!fit) nerr++;
      chk("wr_addr", 32'(wq[j][35:32]), 32'((base % NW + j) % NW));
      chk("wr_data", wq[j][31:0], w);
    end
    chk("fit_err_pulses", fe_cnt, nerr);
    err_model = (err_model + nerr > 255) ? 255 : err_model + nerr;
    chk("err_count", err_count, err_model);
    if (ncl > 0 && wcq.size() > 0) begin
      chk("done_after_last", done_cyc, wcq[wcq.size()-1] + 1);
      if (gmode == 0) begin
        chk("encode_latency", wcq[0], first_acc + 1);
        chk("throughput", wcq[wcq.size()-1], wcq[0] + wcq.size() - 1);
      end
    end
  endtask

  initial begin
    tbl[0] = '{'{2'd3, 6'h30, 12'h001, 24'h000000}, 32'hF0000001, 1'b1};
    tbl[1] = '{'{2'd1, 6'h00, 12'h100, 24'h000010}, 32'h40100001, 1'b1};
    tbl[2] = '{'{2'd2, 6'h05, 12'hAB0, 24'h123400}, 32'h851234AB, 1'b1};
    tbl[3] = '{'{2'd0, 6'h00, 12'h000, 24'hABCDEF}, 32'h00ABCDEF, 1'b1};
    tbl[4] = '{'{2'd0, 6'h00, 12'h001, 24'h000004}, 32'h00000004, 1'b0};
    tbl[5] = '{'{2'd1, 6'h3F, 12'hFFF, 24'hFFFFFF}, 32'h7FFFFFFF, 1'b0};
    tbl[6] = '{'{2'd2, 6'h2A, 12'h00F, 24'h0000FF}, 32'hAA000000, 1'b0};
    tbl[7] = '{'{2'd3, 6'h01, 12'hABC, 24'h456000}, 32'hC1456ABC, 1'b1};

    NRES = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0; mem_gnt = 1'b0;
    in_ecode = '0; in_icode = '0; in_rcode = '0; in_dcode = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_fit_err", fit_err, 0);
    chk("rst_err_count", err_count, 0);
    @(posedge CLK); #1;
    NRES = 1'b1;

    for (int t = 0; t < 8; t++) begin
      stim_q.delete();
      stim_q.push_back(tbl[t].f);
      do_load((t == 0) ? 0 : t * 3, 1, 0);
      if (wq.size() > 0) begin
        chk("tbl_word", wq[0][31:0], tbl[t].w);
        if (tbl[t].fit) chk("roundtrip", decode(wq[0][31:0]) == tbl[t].f, 1);
      end
    end
    chk("tbl_err_total", err_count, 3);

    // Wrap past the top of memory, then clamp an oversize count.
    stim_q.delete();
    for (int j = 0; j < 4; j++) stim_q.push_back(rand_fld(0));
    do_load(6, 4, 0);
    if (wq.size() == 4) chk("wrap_third_addr", 32'(wq[2][35:32]), 0);
    stim_q.delete();
    for (int j = 0; j < 8; j++) stim_q.push_back(rand_fld(0));
    do_load(2, 12, 0);

    stim_q.delete();
    for (int j = 0; j < 4; j++) stim_q.push_back(rand_fld(0));
    do_load(0, 4, 2);

    stim_q.delete();
    do_load(5, 0, 0);

    for (int n = 0; n < 25; n++) begin
      int c;
      c = $urandom_range(0, 20);
      stim_q.delete();
      for (int j = 0; j < ((c > NW) ? NW : c); j++) stim_q.push_back(rand_fld(0));
      do_load($urandom_range(0, 15), c, 1);
    end

    for (int n = 0; n < 38; n++) begin
      stim_q.delete();
      for (int j = 0; j < 8; j++) stim_q.push_back(rand_fld(1));
      do_load($urandom_range(0, 7), 8, 0);
    end
    chk("err_saturated", err_count, 255);

    // Reset in the middle of a load with words held in the FIFO.
    start = 1'b1; base_addr = '0; count = 5'd4;
    @(posedge CLK); #1;
    start = 1'b0; in_valid = 1'b1; mem_gnt = 1'b0;
    {in_ecode, in_icode, in_rcode, in_dcode} = rand_fld(1);
    repeat (3) begin @(posedge CLK); #1; end
    mem_gnt = 1'b1;
    #1;
    chk("pre_rst_we", mem_we, 1);
    NRES = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_fit_err", fit_err, 0);
    chk("mid_rst_err_count", err_count, 0);
    in_valid = 1'b0; mem_gnt = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    NRES = 1'b1;
    err_model = 0;
    stim_q.delete();
    stim_q.push_back(tbl[0].f);
    do_load(3, 1, 0);
    if (wq.size() > 0) chk("post_rst_addr", 32'(wq[0][35:32]), 3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
